// File: rtl/hilo_div_unit.sv
// hilo_div_unit
//   HI/LO register file for the five-stage MIPS pipeline. It computes
//   HI/LO-writing results in the execute stage (MTHI, MTLO, MULT, MULTU,
//   DIV, DIVU) and stages them in a memory-stage pending register. The
//   pending register is committed on hilo_writeM. The HI/LO read ports
//   forward a committing pending value.
//
//   Optional feature macro: HILO_DIV_EN
//     defined   : 32-step restoring divider with FSM and execute-stage stall
//     undefined : no divider; DIV/DIVU stage zeros into HI and LO, no stall
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous reset, active low
//   hilo_opE     in   [2:0] execute op (0 none,1 MTHI,2 MTLO,3 MULT,4 MULTU,
//                     5 DIV,6 DIVU,7 none)
//   srcaE        in   [31:0] rs operand
//   srcbE        in   [31:0] rt operand
//   flushE       in   execute-stage flush
//   hilo_writeM  in   commit strobe for the pending register
//   hi_o, lo_o   out  [31:0] HI/LO read values with forwarding
//   div_stallE   out  holds F/D/E while a divide is incomplete
module hilo_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  hilo_opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        hilo_writeM,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_stallE
);

  localparam logic [2:0] OP_MTHI  = 3'd1;
  localparam logic [2:0] OP_MTLO  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;
  localparam logic [4:0] LAST_CNT = 5'(DIV_CYCLES - 1);

  logic [31:0] hi_r, lo_r;
  logic [31:0] pend_hi_r, pend_lo_r;
  logic [1:0]  pend_we_r;
  logic [31:0] res_hi_s, res_lo_s;
  logic [1:0]  op_we_s, res_we_s;
  logic [31:0] div_hi_s, div_lo_s;
  logic [63:0] smul_s, umul_s;

  assign smul_s = $signed({{32{srcaE[31]}}, srcaE}) * $signed({{32{srcbE[31]}}, srcbE});
  assign umul_s = {32'd0, srcaE} * {32'd0, srcbE};

`ifdef HILO_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  div_state_t  state_r, next_state_s;
  logic [4:0]  cnt_r;
  logic [63:0] rq_r;          // {partial remainder, dividend/quotient bits}
  logic [31:0] divisor_r;
  logic        neg_q_r, neg_r_r, dbz_r;
  logic        is_div_s, signed_s, start_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] trial_s;
  logic        ge_s;
  logic [31:0] sub_s, new_rem_s;
  logic [31:0] q_mag_s, r_mag_s;

  assign is_div_s = (hilo_opE == OP_DIV) || (hilo_opE == OP_DIVU);
  assign signed_s = (hilo_opE == OP_DIV);
  assign start_s  = (state_r == ST_IDLE) && is_div_s && !flushE;
  assign mag_a_s  = (signed_s && srcaE[31]) ? (32'd0 - srcaE) : srcaE;
  assign mag_b_s  = (signed_s && srcbE[31]) ? (32'd0 - srcbE) : srcbE;

  // Restoring step: trial = 2*rem + next dividend bit. When it fits, the
  // true difference is below the divisor, so a 32-bit subtract suffices.
  assign trial_s   = rq_r[63:31];
  assign ge_s      = trial_s >= {1'b0, divisor_r};
  assign sub_s     = trial_s[31:0] - divisor_r;
  assign new_rem_s = ge_s ? sub_s : trial_s[31:0];

  // Sign correction; divide by zero forces an all-ones quotient while the
  // remainder magnitude already equals the dividend.
  assign q_mag_s  = rq_r[31:0];
  assign r_mag_s  = rq_r[63:32];
  assign div_lo_s = dbz_r ? 32'hFFFF_FFFF : (neg_q_r ? (32'd0 - q_mag_s) : q_mag_s);
  assign div_hi_s = neg_r_r ? (32'd0 - r_mag_s) : r_mag_s;

  // Divider state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Divider next state and execute-stage stall.
  always_comb begin
    next_state_s = state_r;
    div_stallE   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_BUSY;
          div_stallE   = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flushE) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          next_state_s = ST_DONE;
          div_stallE   = 1'b1;
        end else begin
          next_state_s = ST_BUSY;
          div_stallE   = 1'b1;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Divider datapath: operand load, one restoring step per busy cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 5'd0;
      rq_r      <= 64'd0;
      divisor_r <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dbz_r     <= 1'b0;
    end else if (start_s) begin
      cnt_r     <= 5'd0;
      rq_r      <= {32'd0, mag_a_s};
      divisor_r <= mag_b_s;
      neg_q_r   <= signed_s && (srcaE[31] ^ srcbE[31]);
      neg_r_r   <= signed_s && srcaE[31];
      dbz_r     <= (srcbE == 32'd0);
    end else if (state_r == ST_BUSY && !flushE) begin
      cnt_r <= cnt_r + 5'd1;
      rq_r  <= {new_rem_s, rq_r[30:0], ge_s};
    end else if (flushE) begin
      cnt_r <= 5'd0;
    end
  end
`else
  logic unused_cfg_s;

  assign unused_cfg_s = ^LAST_CNT;
  assign div_stallE   = 1'b0;
  assign div_hi_s     = 32'd0;
  assign div_lo_s     = 32'd0;
`endif

  // Execute-stage result selection for the pending register.
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    op_we_s  = 2'b00;
    case (hilo_opE)
      OP_MTHI: begin
        res_hi_s = srcaE;
        op_we_s  = 2'b10;
      end
      OP_MTLO: begin
        res_lo_s = srcaE;
        op_we_s  = 2'b01;
      end
      OP_MULT: begin
        {res_hi_s, res_lo_s} = smul_s;
        op_we_s              = 2'b11;
      end
      OP_MULTU: begin
        {res_hi_s, res_lo_s} = umul_s;
        op_we_s              = 2'b11;
      end
      OP_DIV, OP_DIVU: begin
        res_hi_s = div_hi_s;
        res_lo_s = div_lo_s;
        op_we_s  = 2'b11;
      end
      default: op_we_s = 2'b00;
    endcase
    res_we_s = flushE ? 2'b00 : op_we_s;
  end

  // Pending register: loads when E advances; while E is held, a commit
  // clears the write enables so the same value is never written twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 2'b00;
    end else if (!div_stallE) begin
      pend_hi_r <= res_hi_s;
      pend_lo_r <= res_lo_s;
      pend_we_r <= res_we_s;
    end else if (hilo_writeM) begin
      pend_we_r <= 2'b00;
    end
  end

  // Architectural HI/LO commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (hilo_writeM) begin
      if (pend_we_r[1]) hi_r <= pend_hi_r;
      if (pend_we_r[0]) lo_r <= pend_lo_r;
    end
  end

  assign hi_o = (hilo_writeM && pend_we_r[1]) ? pend_hi_r : hi_r;
  assign lo_o = (hilo_writeM && pend_we_r[0]) ? pend_lo_r : lo_r;

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO register file with an iterative 32-cycle divider for the five-stage MIPS pipeline. It is the consumer end of the controller's `hilo_writeM` strobe. It accepts HI/LO-writing operations in the execute stage: MTHI, MTLO, MULT, MULTU, DIV and DIVU. Results are staged into a memory-stage pending register and committed to HI/LO when `hilo_writeM` is asserted. While a divide is in flight, the unit asserts a stall toward the hazard logic.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: divider iteration count. It is fixed at the operand width; no other value is supported.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserted (0) clears all state immediately.
- `hilo_opE`  in  3  execute-stage op:
  - 000 none
  - 001 MTHI
  - 010 MTLO
  - 011 MULT
  - 100 MULTU
  - 101 DIV
  - 110 DIVU
  - 111 reserved, treated as none.
- `srcaE`  in  32  rs operand (dividend / multiplicand / MT source).
- `srcbE`  in  32  rt operand (divisor / multiplier).
- `flushE`  in  1  execute-stage flush.
- `hilo_writeM`  in  1  commit strobe from the controller, memory stage.
- `hi_o`, `lo_o`  out  32 each  HI/LO read values for MFHI/MFLO, with forwarding.
- `div_stallE`  out  1  holds the F/D/E stages while a divide is incomplete.

## Operation
- **State:**
  - `hi_r`, `lo_r` (architectural).
  - Pending register `pend_hi`, `pend_lo`, `pend_we[1:0]` ({hi,lo}).
  - Divider FSM plus a 5-bit counter, 64-bit remainder/quotient shift register, and sign flags.
- **E-stage result computation** (registered into pending on every non-stalled edge):
  - MTHI: `pend_hi=srcaE`, `pend_we=10`.
  - MTLO: `pend_lo=srcaE`, `pend_we=01`.
  - MULT: signed 32x32, `{pend_hi,pend_lo}=product`, `pend_we=11`.
  - MULTU: unsigned 32x32, same as MULT.
  - DIV/DIVU: `pend_lo=quotient`, `pend_hi=remainder`, `pend_we=11`. Captured only in the DONE cycle.
  - none, or `flushE`=1: `pend_we=00`.
- **Commit:** on each edge, if `hilo_writeM`=1, HI is written where `pend_we[1]`=1 and LO where `pend_we[0]`=1.
- **Read forwarding:** if `hilo_writeM`=1 and `pend_we[1]`=1, `hi_o=pend_hi`; otherwise `hi_o=hi_r`. `lo_o` works the same way.
- **Divider FSM:**
  - IDLE: on DIV/DIVU, load magnitudes and latch signs (DIV only), clear the counter, go to BUSY.
  - BUSY: one restoring step per cycle. At count 31, go to DONE.
  - DONE: sign-correct the outputs, then return to IDLE on the next edge.
- **Divider arithmetic:**
  - Signed: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero: quotient=`32'hFFFFFFFF`, remainder=dividend. The full 33-cycle sequence still runs.
  - `32'h80000000 / -1` signed gives quotient `32'h80000000`, remainder 0.
- **Flush:** `flushE` in any FSM state aborts to IDLE, deasserts the stall and stages nothing.

## Timing
- **Reset values:**
  - `hi_r=lo_r=0`, `pend_we=00`, `pend_hi=pend_lo=0`.
  - FSM=IDLE, counter=0.
  - Therefore `hi_o=lo_o=0` and `div_stallE=0`.
- **MT/MULT latency:** op in E at cycle n, pending at n+1, HI/LO updated at n+2 (if `hilo_writeM`). Visible through `hi_o`/`lo_o` from cycle n+1.
- **Divide stall:** `div_stallE`=1 combinationally in the IDLE cycle when DIV/DIVU is in E, and throughout BUSY. That is 33 stall cycles. It is 0 in DONE, so the divide advances and its result is staged at the DONE-cycle edge.
- **Back-to-back divides:** the second divide enters E in the cycle after DONE, with the FSM in IDLE, and restarts cleanly.
- **Commit during a divide:** a pending commit proceeds while the divide is stalled. Pending is only overwritten when E advances; while stalled, `pend_we` is forced to 00 after its first commit edge, so nothing is written twice.
- **Async reset mid-divide:** FSM to IDLE, the stall drops immediately and partial results are discarded.

## Configuration
- **`HILO_DIV_EN` defined:** the divider, FSM and stall logic are compiled in, as described above.
- **`HILO_DIV_EN` undefined:**
  - No divider logic is compiled; `div_stallE` is tied to 0.
  - DIV/DIVU stage `pend_hi=pend_lo=0` with `pend_we=11`.
  - MT/MULT behaviour is unchanged.

## Test plan
- **Reset:** deassert `rst` after 3 cycles -> `hi_o=lo_o=0`, `div_stallE=0`.
- **Signed multiply:** MULT `srcaE=-3` (`FFFFFFFD`), `srcbE=7`, then `hilo_writeM`=1 next cycle -> `hi_o=FFFFFFFF`, `lo_o=FFFFFFEB`. MULTU with the same operands -> `hi_o=00000006`, `lo_o=FFFFFFEB`.
- **Signed divide:** DIV `-7/2` -> stall for exactly 33 cycles, then `lo=FFFFFFFD`, `hi=FFFFFFFF`. DIVU `100/7` -> `lo=14`, `hi=2`.
- **Divide by zero:** DIVU `5/0` -> `lo=FFFFFFFF`, `hi=5`, 33-cycle stall.
- **Forwarding:** MTHI `12345678` followed immediately by a read -> `hi_o=12345678` in cycle n+1. With `hilo_writeM`=0 at commit, `hi_o` returns to its old value.
- **Abort:** `flushE` at BUSY count 10 -> stall drops the same cycle, HI/LO unchanged. Async reset at count 20 -> FSM IDLE, `hi_o=lo_o=0`.
